// File: rtl/sram_output_ctrl_if.sv
// Request/readout handshakes and SRAM macro pins for the output-SRAM controller.
// The slave modport is the controller's view; master is the surrounding logic and SRAM.
interface sram_output_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128
);
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_acc;

  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic              busy;

  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  modport slave (
    input  w_valid, w_addr, w_data, w_acc,
    output w_ready,
    input  r_valid, r_addr,
    output r_ready, r_rdata, r_rvalid,
    output busy,
    output sram_cen, sram_wen, sram_a, sram_d,
    input  sram_q
  );

  modport master (
    output w_valid, w_addr, w_data, w_acc,
    input  w_ready,
    output r_valid, r_addr,
    input  r_ready, r_rdata, r_rvalid,
    input  busy,
    input  sram_cen, sram_wen, sram_a, sram_d,
    output sram_q
  );
endinterface

// File: rtl/sram_output_ctrl.sv
// Arbiter and cycle sequencer for the output SRAM: plain writes, host reads and
// read-add-write lanewise accumulation, all through registered SRAM pins.
module sram_output_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128,
  parameter int LANE_W = 16,
  parameter int SAT    = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  sram_output_ctrl_if.slave    bus
);

  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    ACC_ISSUE,
    ACC_ADD
  } state_e;

  state_e            state_q, state_d;
  logic              prio_w_q, prio_w_d;
  logic              sram_cen_q, sram_cen_d;
  logic              sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [DATA_W-1:0] sram_d_q, sram_d_d;
  logic [DATA_W-1:0] acc_data_q, acc_data_d;
  logic [DATA_W-1:0] r_rdata_q, r_rdata_d;
  logic              r_rvalid_q, r_rvalid_d;

  logic              grant_w;
  logic              grant_r;
  logic [DATA_W-1:0] acc_sum;

  // Two's-complement lane add; on overflow both operands share a sign, so the
  // clamp direction follows that sign.
  function automatic logic [LANE_W-1:0] lane_add(
    input logic [LANE_W-1:0] x,
    input logic [LANE_W-1:0] y
  );
    logic [LANE_W-1:0] raw;
    logic              ovf;
    raw = x + y;
    ovf = (x[LANE_W-1] == y[LANE_W-1]) && (raw[LANE_W-1] != x[LANE_W-1]);
    if ((SAT != 0) && ovf) begin
      raw = x[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
    return raw;
  endfunction

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_sum[i*LANE_W +: LANE_W] = lane_add(bus.sram_q[i*LANE_W +: LANE_W],
                                             acc_data_q[i*LANE_W +: LANE_W]);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    prio_w_d   = prio_w_q;
    sram_cen_d = 1'b1;
    sram_wen_d = 1'b1;
    sram_a_d   = sram_a_q;
    sram_d_d   = sram_d_q;
    acc_data_d = acc_data_q;
    r_rdata_d  = r_rdata_q;
    r_rvalid_d = 1'b0;
    grant_w    = 1'b0;
    grant_r    = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_w = bus.w_valid && (!bus.r_valid || prio_w_q);
        grant_r = bus.r_valid && !grant_w;
        if (grant_w) begin
          prio_w_d   = 1'b0;
          sram_cen_d = 1'b0;
          sram_a_d   = bus.w_addr;
          if (bus.w_acc) begin
            acc_data_d = bus.w_data;
            state_d    = ACC_ISSUE;
          end else begin
            sram_wen_d = 1'b0;
            sram_d_d   = bus.w_data;
          end
        end else if (grant_r) begin
          prio_w_d   = 1'b1;
          sram_cen_d = 1'b0;
          sram_a_d   = bus.r_addr;
          state_d    = RD_ISSUE;
        end
      end
      // The read was launched on the accepting edge; this cycle the SRAM samples it.
      RD_ISSUE:  state_d = RD_DATA;
      RD_DATA: begin
        r_rdata_d  = bus.sram_q;
        r_rvalid_d = 1'b1;
        state_d    = IDLE;
      end
      ACC_ISSUE: state_d = ACC_ADD;
      ACC_ADD: begin
        sram_cen_d = 1'b0;
        sram_wen_d = 1'b0;
        sram_d_d   = acc_sum;
        state_d    = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      prio_w_q   <= 1'b1;
      sram_cen_q <= 1'b1;
      sram_wen_q <= 1'b1;
      sram_a_q   <= '0;
      sram_d_q   <= '0;
      acc_data_q <= '0;
      r_rdata_q  <= '0;
      r_rvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      prio_w_q   <= prio_w_d;
      sram_cen_q <= sram_cen_d;
      sram_wen_q <= sram_wen_d;
      sram_a_q   <= sram_a_d;
      sram_d_q   <= sram_d_d;
      acc_data_q <= acc_data_d;
      r_rdata_q  <= r_rdata_d;
      r_rvalid_q <= r_rvalid_d;
    end
  end

  assign bus.w_ready  = grant_w;
  assign bus.r_ready  = grant_r;
  assign bus.r_rdata  = r_rdata_q;
  assign bus.r_rvalid = r_rvalid_q;
  assign bus.busy     = (state_q != IDLE) || !sram_cen_q;
  assign bus.sram_cen = sram_cen_q;
  assign bus.sram_wen = sram_wen_q;
  assign bus.sram_a   = sram_a_q;
  assign bus.sram_d   = sram_d_q;

endmodule

// File: tb/tb_sram_output_ctrl.sv
// Directed bench: a saturating and a wrapping controller share one stimulus
// stream, each in front of its own behavioural 2048x128 SRAM.
module tb_sram_output_ctrl;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 128;

  logic clk;
  logic RESET_N;

  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_acc;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  int n_checks = 0;
  int n_fail   = 0;

  sram_output_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_s ();
  sram_output_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_w ();

  assign bus_s.w_valid = w_valid;
  assign bus_s.w_addr  = w_addr;
  assign bus_s.w_data  = w_data;
  assign bus_s.w_acc   = w_acc;
  assign bus_s.r_valid = r_valid;
  assign bus_s.r_addr  = r_addr;
  assign bus_w.w_valid = w_valid;
  assign bus_w.w_addr  = w_addr;
  assign bus_w.w_data  = w_data;
  assign bus_w.w_acc   = w_acc;
  assign bus_w.r_valid = r_valid;
  assign bus_w.r_addr  = r_addr;

  sram_output_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(16), .SAT(1)) dut_sat (
    .CLK     (clk),
    .RESET_N (RESET_N),
    .bus     (bus_s)
  );

  sram_output_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(16), .SAT(0)) dut_wrap (
    .CLK     (clk),
    .RESET_N (RESET_N),
    .bus     (bus_w)
  );

  // NOTE: the SRAM array has no reset, like the real macro; only addresses
  // the bench has written are ever read back.
  logic [DATA_W-1:0] mem_s [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_w [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] q_s, q_w;

  always @(posedge clk) begin
    if (!bus_s.sram_cen) begin
      if (!bus_s.sram_wen) mem_s[bus_s.sram_a] <= bus_s.sram_d;
      else                 q_s <= mem_s[bus_s.sram_a];
    end
    if (!bus_w.sram_cen) begin
      if (!bus_w.sram_wen) mem_w[bus_w.sram_a] <= bus_w.sram_d;
      else                 q_w <= mem_w[bus_w.sram_a];
    end
  end

  assign bus_s.sram_q = q_s;
  assign bus_w.sram_q = q_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] lanes(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Issues one write (plain or accumulate); returns in the cycle the
  // controller is back in IDLE.
  task automatic write_op(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic acc, input string tag);
    w_valid = 1'b1;
    w_addr  = addr;
    w_data  = data;
    w_acc   = acc;
    #1;
    for (int k = 0; k < 8 && !bus_s.w_ready; k++) begin
      tick();
      #1;
    end
    check({tag, " w_ready"}, bus_s.w_ready, 1'b1);
    tick();
    w_valid = 1'b0;
    w_acc   = 1'b0;
    if (acc) begin
      tick();
      tick();
    end
  endtask

  // Issues one read and checks return latency and data from both controllers.
  task automatic read_op(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_s,
                         input logic [DATA_W-1:0] exp_w, input string tag);
    int lat;
    r_valid = 1'b1;
    r_addr  = addr;
    #1;
    for (int k = 0; k < 8 && !bus_s.r_ready; k++) begin
      tick();
      #1;
    end
    check({tag, " r_ready"}, bus_s.r_ready, 1'b1);
    tick();
    r_valid = 1'b0;
    lat = 1;
    while (bus_s.r_rvalid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " rdata sat"}, bus_s.r_rdata, exp_s);
    check({tag, " rvalid wrap"}, bus_w.r_rvalid, 1'b1);
    check({tag, " rdata wrap"}, bus_w.r_rdata, exp_w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    w_valid = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_acc   = 1'b0;
    r_valid = 1'b0;
    r_addr  = '0;
    tick();
    tick();

    check("reset cen", bus_s.sram_cen, 1'b1);
    check("reset wen", bus_s.sram_wen, 1'b1);
    check("reset a", bus_s.sram_a, '0);
    check("reset d", bus_s.sram_d, '0);
    check("reset rdata", bus_s.r_rdata, '0);
    check("reset rvalid", bus_s.r_rvalid, 1'b0);
    check("reset busy", bus_s.busy, 1'b0);
    RESET_N = 1'b1;
    tick();

    // Back-to-back plain writes, then read back the second one.
    w_valid = 1'b1; w_addr = 11'd5; w_data = lanes(16'h0AAA); w_acc = 1'b0;
    r_valid = 1'b0;
    #1;
    check("wr5 w_ready", bus_s.w_ready, 1'b1);
    check("wr5 r_ready", bus_s.r_ready, 1'b0);
    tick();
    check("wr5 pins cen", bus_s.sram_cen, 1'b0);
    check("wr5 pins wen", bus_s.sram_wen, 1'b0);
    check("wr5 pins a", bus_s.sram_a, 11'd5);
    check("wr5 pins d", bus_s.sram_d, lanes(16'h0AAA));
    w_addr = 11'd6; w_data = lanes(16'h0BBB);
    #1;
    check("wr6 w_ready", bus_s.w_ready, 1'b1);
    tick();
    w_valid = 1'b0;
    check("wr6 pins a", bus_s.sram_a, 11'd6);
    check("wr6 busy", bus_s.busy, 1'b1);
    read_op(11'd6, lanes(16'h0BBB), lanes(16'h0BBB), "rd6");

    // Accumulate with a competing write held up for two cycles.
    write_op(11'd10, lanes(16'h0005), 1'b0, "wr10");
    w_valid = 1'b1; w_addr = 11'd10; w_data = lanes(16'h0003); w_acc = 1'b1;
    #1;
    check("acc10 w_ready", bus_s.w_ready, 1'b1);
    tick();
    w_addr = 11'd11; w_data = lanes(16'h1234); w_acc = 1'b0;
    #1;
    check("acc10 t+1 w_ready", bus_s.w_ready, 1'b0);
    check("acc10 t+1 busy", bus_s.busy, 1'b1);
    check("acc10 t+1 cen", bus_s.sram_cen, 1'b0);
    check("acc10 t+1 wen", bus_s.sram_wen, 1'b1);
    check("acc10 t+1 a", bus_s.sram_a, 11'd10);
    tick();
    check("acc10 t+2 w_ready", bus_s.w_ready, 1'b0);
    tick();
    check("acc10 t+3 wen", bus_s.sram_wen, 1'b0);
    check("acc10 t+3 d", bus_s.sram_d, lanes(16'h0008));
    check("acc10 t+3 w_ready", bus_s.w_ready, 1'b1);
    tick();
    w_valid = 1'b0;
    read_op(11'd10, lanes(16'h0008), lanes(16'h0008), "rd10");

    // Saturation vs wrap, positive and negative overflow.
    write_op(11'd20, lanes(16'h7FF0), 1'b0, "wr20");
    write_op(11'd20, lanes(16'h0100), 1'b1, "acc20");
    read_op(11'd20, lanes(16'h7FFF), lanes(16'h80F0), "rd20");
    write_op(11'd21, lanes(16'h8000), 1'b0, "wr21");
    write_op(11'd21, lanes(16'hFFFF), 1'b1, "acc21");
    // Read issued in the cycle the accumulate returns to IDLE.
    read_op(11'd21, lanes(16'h8000), lanes(16'h7FFF), "rd21");

    // Both requesters held valid: grants alternate W,R with read latency 3.
    w_valid = 1'b1; w_acc = 1'b0; r_valid = 1'b1; r_addr = 11'd5;
    for (int n = 0; n < 2; n++) begin
      w_addr = 11'd40 + 11'(n);
      w_data = lanes(16'h1000 + 16'(n));
      #1;
      check($sformatf("alt%0d W grant", n), bus_s.w_ready, 1'b1);
      check($sformatf("alt%0d W r_ready", n), bus_s.r_ready, 1'b0);
      if (n > 0) begin
        check($sformatf("alt%0d prev rvalid", n), bus_s.r_rvalid, 1'b1);
        check($sformatf("alt%0d prev rdata", n), bus_s.r_rdata, lanes(16'h0AAA));
      end
      tick();
      check($sformatf("alt%0d R grant", n), bus_s.r_ready, 1'b1);
      check($sformatf("alt%0d R w_ready", n), bus_s.w_ready, 1'b0);
      tick();
      if (n == 1) begin
        w_valid = 1'b0;
        r_valid = 1'b0;
      end
      #1;
      check($sformatf("alt%0d issue rvalid", n), bus_s.r_rvalid, 1'b0);
      check($sformatf("alt%0d issue w_ready", n), bus_s.w_ready, 1'b0);
      tick();
      check($sformatf("alt%0d data rvalid", n), bus_s.r_rvalid, 1'b0);
      tick();
    end
    check("alt last rvalid", bus_s.r_rvalid, 1'b1);
    check("alt last rdata", bus_s.r_rdata, lanes(16'h0AAA));
    tick();
    read_op(11'd41, lanes(16'h1001), lanes(16'h1001), "rd41");

    // Reset during ACC_ADD aborts the accumulate write.
    write_op(11'd50, lanes(16'h1111), 1'b0, "wr50");
    w_valid = 1'b1; w_addr = 11'd50; w_data = lanes(16'h0001); w_acc = 1'b1;
    tick();
    w_valid = 1'b0; w_acc = 1'b0;
    tick();
    RESET_N = 1'b0;
    #1;
    check("rst cen", bus_s.sram_cen, 1'b1);
    check("rst rvalid", bus_s.r_rvalid, 1'b0);
    check("rst busy", bus_s.busy, 1'b0);
    tick();
    RESET_N = 1'b1;
    tick();
    read_op(11'd50, lanes(16'h1111), lanes(16'h1111), "rd50");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
